// File: rtl/fare_account.sv
// rtl/fare_account.sv - fare card account table with tap/debit FSM and top-up handshake (optional FARE_TXN_COUNT_EN)
module fare_account #(
    parameter int NUM_CARDS = 8,
    parameter int BAL_W     = 8,
    parameter int FARE      = 3,
    parameter int TIMEOUT   = 4,
    localparam int ID_W     = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             nfc,
    input  logic [ID_W-1:0]  card_id,
    output logic             card_active,
    output logic             fund_enough,
    input  logic             reduce_bal,
    output logic             busy,
    output logic             debit_done,
    output logic             debit_err,
    input  logic             topup_valid,
    input  logic [ID_W-1:0]  topup_id,
    input  logic [BAL_W-1:0] topup_amt,
`ifdef FARE_TXN_COUNT_EN
    output logic [15:0]      txn_count,
`endif
    output logic             topup_ready
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [ID_W:0]    NUM_C     = (ID_W + 1)'(NUM_CARDS);
    localparam logic [BAL_W-1:0] FARE_AMT  = BAL_W'(FARE);
    localparam logic [BAL_W-1:0] BAL_MAX   = {BAL_W{1'b1}};

    typedef enum logic [1:0] {IDLE, HOLD, DEBIT} state_t;

    state_t             state, state_next;
    logic [BAL_W-1:0]   bal    [NUM_CARDS];
    logic               active [NUM_CARDS];
    logic [ID_W-1:0]    cur_id;
    logic [TMR_W-1:0]   timer;
    logic               reduce_q;
    logic               rise;
    logic               tap, refuse;
    logic               tap_exists, topup_exists;
    logic               topup_fire;
    logic [BAL_W:0]     topup_sum;

    assign rise         = reduce_bal & ~reduce_q;
    assign busy         = (state != IDLE);
    assign topup_ready  = (state == IDLE) && !nfc;
    assign topup_fire   = topup_valid && topup_ready;
    assign tap_exists   = ({1'b0, card_id} < NUM_C);
    assign topup_exists = ({1'b0, topup_id} < NUM_C);
    assign topup_sum    = {1'b0, bal[topup_id]} + {1'b0, topup_amt};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tap        = 1'b0;
        refuse     = 1'b0;
        case (state)
            IDLE: begin
                if (nfc) begin
                    state_next = HOLD;
                    tap        = 1'b1;
                end
            end
            HOLD: begin
                if (rise) begin
                    if (card_active && fund_enough) begin
                        state_next = DEBIT;
                    end else begin
                        state_next = IDLE;
                        refuse     = 1'b1;
                    end
                end else if (timer == TMR_LAST) begin
                    state_next = IDLE;
                end
            end
            DEBIT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The debit is committed on the edge leaving DEBIT, so a reset during DEBIT wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CARDS; i++) begin
                bal[i]    <= '0;
                active[i] <= 1'b0;
            end
            cur_id      <= '0;
            timer       <= '0;
            reduce_q    <= 1'b0;
            card_active <= 1'b0;
            fund_enough <= 1'b0;
            debit_done  <= 1'b0;
            debit_err   <= 1'b0;
`ifdef FARE_TXN_COUNT_EN
            txn_count   <= '0;
`endif
        end else begin
            reduce_q   <= reduce_bal;
            debit_done <= 1'b0;
            debit_err  <= refuse;
            if (tap) begin
                cur_id      <= card_id;
                timer       <= '0;
                card_active <= tap_exists && active[card_id];
                fund_enough <= tap_exists && active[card_id] && (bal[card_id] >= FARE_AMT);
            end
            if (state == HOLD) begin
                timer <= timer + TMR_W'(1);
            end
            if (state == DEBIT) begin
                bal[cur_id] <= bal[cur_id] - FARE_AMT;
                debit_done  <= 1'b1;
`ifdef FARE_TXN_COUNT_EN
                txn_count   <= txn_count + 16'd1;
`endif
            end
            if (state != IDLE && state_next == IDLE) begin
                card_active <= 1'b0;
                fund_enough <= 1'b0;
            end
            if (topup_fire && topup_exists) begin
                bal[topup_id]    <= topup_sum[BAL_W] ? BAL_MAX : topup_sum[BAL_W-1:0];
                active[topup_id] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fare_account.sv
// tb/tb_fare_account.sv - directed self-checking bench for fare_account
module tb_fare_account;

    logic       clk = 1'b0;
    logic       rst;
    logic       nfc;
    logic [2:0] card_id;
    logic       card_active;
    logic       fund_enough;
    logic       reduce_bal;
    logic       busy;
    logic       debit_done;
    logic       debit_err;
    logic       topup_valid;
    logic [2:0] topup_id;
    logic [7:0] topup_amt;
    logic       topup_ready;
`ifdef FARE_TXN_COUNT_EN
    logic [15:0] txn_count;
`endif

    int tests = 0;
    int fails = 0;
    int pulses;

    always #5 clk = ~clk;

    fare_account dut (
        .clk         (clk),
        .rst         (rst),
        .nfc         (nfc),
        .card_id     (card_id),
        .card_active (card_active),
        .fund_enough (fund_enough),
        .reduce_bal  (reduce_bal),
        .busy        (busy),
        .debit_done  (debit_done),
        .debit_err   (debit_err),
        .topup_valid (topup_valid),
        .topup_id    (topup_id),
        .topup_amt   (topup_amt),
`ifdef FARE_TXN_COUNT_EN
        .txn_count   (txn_count),
`endif
        .topup_ready (topup_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic topup(input logic [2:0] id, input logic [7:0] amt);
        topup_valid = 1'b1;
        topup_id    = id;
        topup_amt   = amt;
        tick();
        topup_valid = 1'b0;
    endtask

    task automatic tap(input logic [2:0] id);
        nfc     = 1'b1;
        card_id = id;
        tick();
        nfc     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; nfc = 1'b0; card_id = '0; reduce_bal = 1'b0;
        topup_valid = 1'b0; topup_id = '0; topup_amt = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_card_active", card_active, 0);
        check("rst_fund_enough", fund_enough, 0);
        check("rst_busy", busy, 0);
        check("rst_debit_done", debit_done, 0);
        check("rst_debit_err", debit_err, 0);
        check("rst_topup_ready", topup_ready, 1);
        check("rst_bal2", dut.bal[2], 0);

        // Inactive card: refused debit
        tap(3'd2);
        check("inact_active", card_active, 0);
        check("inact_fund", fund_enough, 0);
        check("inact_busy", busy, 1);
        check("inact_topup_ready", topup_ready, 0);
        reduce_bal = 1'b1;
        tick();
        check("inact_err_pulse", debit_err, 1);
        check("inact_busy_after", busy, 0);
        reduce_bal = 1'b0;
        tick();
        check("inact_err_clear", debit_err, 0);
        check("inact_bal2", dut.bal[2], 0);

        // Top up 10 then debit 3
        topup(3'd2, 8'd10);
        check("topup_bal2", dut.bal[2], 10);
        tap(3'd2);
        check("ok_active", card_active, 1);
        check("ok_fund", fund_enough, 1);
        reduce_bal = 1'b1;
        tick();
        check("ok_debit_busy", busy, 1);
        check("ok_no_done_yet", debit_done, 0);
        tick();
        check("ok_done_pulse", debit_done, 1);
        check("ok_bal2", dut.bal[2], 7);
        check("ok_idle_active", card_active, 0);
        check("ok_idle_busy", busy, 0);
`ifdef FARE_TXN_COUNT_EN
        check("ok_txn_count", txn_count, 1);
`endif
        reduce_bal = 1'b0;
        tick();
        check("ok_done_clear", debit_done, 0);

        // Low balance, timeout
        topup(3'd5, 8'd2);
        tap(3'd5);
        check("low_active", card_active, 1);
        check("low_fund", fund_enough, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("low_busy_hold", busy, 1);
        end
        tick();
        check("low_timeout_idle", busy, 0);
        check("low_timeout_active", card_active, 0);
        check("low_bal5", dut.bal[5], 2);

        // Saturation
        topup(3'd1, 8'd250);
        check("sat_bal1_250", dut.bal[1], 250);
        topup(3'd1, 8'd10);
        check("sat_bal1_255", dut.bal[1], 255);

        // Tap has priority over a concurrent top-up (zero amount on inactive card 7)
        topup_valid = 1'b1; topup_id = 3'd7; topup_amt = 8'd0;
        nfc = 1'b1; card_id = 3'd5;
        #1;
        check("prio_ready_low", topup_ready, 0);
        tick();
        nfc = 1'b0;
        check("prio_tap_served", card_active, 1);
        check("prio_card7_idle", dut.active[7], 0);
        for (int i = 0; i < 4; i++) tick();
        check("prio_ready_back", topup_ready, 1);
        tick();
        topup_valid = 1'b0;
        check("prio_card7_active", dut.active[7], 1);
        check("prio_card7_bal", dut.bal[7], 0);
        tap(3'd7);
        check("zero_topup_active", card_active, 1);
        check("zero_topup_fund", fund_enough, 0);
        for (int i = 0; i < 4; i++) tick();

        // Held reduce_bal gives exactly one debit
        tap(3'd2);
        reduce_bal = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (debit_done) pulses++;
        end
        reduce_bal = 1'b0;
        check("held_one_debit", pulses, 1);
        check("held_bal2", dut.bal[2], 4);

        // Level already high at tap is not an edge
        reduce_bal = 1'b1;
        tap(3'd2);
        tick();
        check("level_no_debit_busy", busy, 1);
        check("level_no_debit_bal", dut.bal[2], 4);
        reduce_bal = 1'b0;
        tick();
        reduce_bal = 1'b1;
        tick();
        check("pre_rst_in_debit", busy, 1);
        check("pre_rst_bal", dut.bal[2], 4);

        // Reset while in DEBIT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reduce_bal = 1'b0;
        check("rstdeb_done", debit_done, 0);
        check("rstdeb_err", debit_err, 0);
        check("rstdeb_busy", busy, 0);
        check("rstdeb_active", card_active, 0);
        check("rstdeb_fund", fund_enough, 0);
        check("rstdeb_bal2", dut.bal[2], 0);
`ifdef FARE_TXN_COUNT_EN
        check("rstdeb_txn", txn_count, 0);
`endif
        tick();
        check("rstdeb_no_late_done", debit_done, 0);
        tap(3'd1);
        check("rst_card1_inactive", card_active, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fare_account.md
FARE_ACCOUNT -- requirements
Module: fare_account

Interface
REQ-001 SHALL have parameter NUM_CARDS, default 8; number of card accounts, IDs 0..NUM_CARDS-1.
REQ-002 SHALL have parameter BAL_W, default 8; balance width in bits.
REQ-003 SHALL have parameter FARE, default 3; amount debited per accepted trip.
REQ-004 SHALL have parameter TIMEOUT, default 4; cycles to wait for a debit request before abandoning a transaction.
REQ-005 SHALL have port clk, input, 1; the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1; synchronous, active-high reset.
REQ-007 SHALL have port nfc, input, 1; tap strobe from the card reader.
REQ-008 SHALL have port card_id, input, clog2(NUM_CARDS); tapped card ID, sampled with nfc.
REQ-009 SHALL have port card_active, output, 1; registered: tapped card exists and is enabled.
REQ-010 SHALL have port fund_enough, output, 1; registered: tapped card balance >= FARE.
REQ-011 SHALL have port reduce_bal, input, 1; debit request from the gate, level, acted on at its rising edge.
REQ-012 SHALL have port busy, output, 1; high whenever the FSM is not IDLE.
REQ-013 SHALL have port debit_done, output, 1; one-cycle pulse when a debit is applied.
REQ-014 SHALL have port debit_err, output, 1; one-cycle pulse when a debit request is refused.
REQ-015 SHALL have ports topup_valid (input, 1), topup_id (input, clog2(NUM_CARDS)), topup_amt (input, BAL_W) and topup_ready (output, 1), forming the top-up handshake.

Function
REQ-016 SHALL implement FSM states IDLE, HOLD and DEBIT.
REQ-017 In IDLE, nfc=1 at an edge SHALL, on that edge, latch card_id and register card_active and fund_enough from the table, then enter HOLD; both outputs are valid from the next cycle.
REQ-018 fund_enough SHALL be 0 whenever card_active is 0.
REQ-019 card_active and fund_enough SHALL hold stable through HOLD and DEBIT and clear to 0 on return to IDLE.
REQ-020 In HOLD, a 0->1 transition of reduce_bal with card_active=1 and fund_enough=1 SHALL enter DEBIT.
REQ-021 DEBIT SHALL subtract FARE from the latched card's balance, pulse debit_done and return to IDLE, all in one cycle.
REQ-022 A reduce_bal rising edge in HOLD while card_active=0 or fund_enough=0 SHALL pulse debit_err, change no balance and return to IDLE.
REQ-023 HOLD SHALL return to IDLE after TIMEOUT cycles without a reduce_bal rising edge.
REQ-024 At most one debit SHALL occur per tap; a reduce_bal level already high on HOLD entry SHALL NOT count as an edge.
REQ-025 nfc SHALL be ignored outside IDLE.
REQ-026 topup_ready SHALL be 1 only when the FSM is in IDLE and nfc=0, so that a tap has priority over a top-up.
REQ-027 A transfer SHALL occur when topup_valid=1 and topup_ready=1 at an edge.
REQ-028 A transfer SHALL add topup_amt to the balance, saturating at 2^BAL_W-1, and SHALL set the card active.
REQ-029 A top-up with topup_amt=0 SHALL only activate the card.
REQ-030 Balance arithmetic SHALL never wrap; the debit path is unreachable when balance < FARE.

Reset
REQ-031 On rst=1 at an edge, the FSM SHALL go to IDLE and all balances SHALL become 0.
REQ-032 On rst=1 at an edge, all cards SHALL become inactive.
REQ-033 On rst=1 at an edge, card_active, fund_enough, busy, debit_done and debit_err SHALL be 0 and the timeout counter SHALL clear.
REQ-034 Reset mid-transaction, including in DEBIT, SHALL abandon the transaction with no debit.
REQ-035 rst SHALL have priority over every other input.

Configuration
REQ-036 With macro FARE_TXN_COUNT_EN defined, the block SHALL add output txn_count (16 bits): it increments on each debit_done, wraps at 65535->0 and resets to 0.
REQ-037 Without FARE_TXN_COUNT_EN, txn_count and its counter SHALL not exist.

Verification
REQ-038 Reset, then tap card 2 -> card_active=0, fund_enough=0 the next cycle; reduce_bal pulse -> debit_err pulse.
REQ-039 Top up card 2 with 10, tap, reduce_bal rising edge -> debit_done pulse; balance becomes 7; txn_count=1 when enabled.
REQ-040 Top up card 5 with 2, tap -> card_active=1, fund_enough=0; no reduce_bal -> IDLE after 4 cycles, balance stays 2.
REQ-041 Top up card 1 with 250 then with 10 -> balance saturates at 255; topup_valid together with nfc in the same cycle -> topup_ready=0, tap served first, top-up accepted afterwards.
REQ-042 reduce_bal held high for 3 cycles -> exactly one debit; rst asserted in DEBIT -> no debit, all outputs 0.
